// File: rtl/mem_access_arbiter.sv
// Two-port arbiter in front of a single-port memory: round-robin or fixed-priority
// ownership with a bounded burst, range checking, and a one-cycle read return path.
module mem_access_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [1:0]            err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [1:0]            owner
);

    localparam int unsigned CntW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    // Encoding doubles as the one-hot owner output.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   burst_q, burst_d;
    logic              last_q, last_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;

    logic              sel;
    logic              tie_w;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              in_range;
    logic [1:0]        gnt_int;
    state_e            other_st;

    assign sel       = (state_q == StOwn1);
    assign sel_addr  = sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    assign sel_wdata = sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    assign sel_we    = we[sel];
    assign in_range  = 32'(sel_addr) < DEPTH;
    assign other_st  = sel ? StOwn0 : StOwn1;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        gnt_int = 2'b00;
        tie_w   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    burst_d = '0;
                    if (req == 2'b11) begin
                        tie_w = (PRIO_MODE != 0) ? 1'b0 : !last_q;
                    end else begin
                        tie_w = req[1];
                    end
                    state_d = tie_w ? StOwn1 : StOwn0;
                end
            end
            StOwn0, StOwn1: begin
                if (req[sel]) begin
                    gnt_int[sel] = 1'b1;
                    last_d       = sel;
                    if (burst_q == CntW'(MAX_BURST - 1)) begin
                        // Burst exhausted: yield only if the other port is waiting.
                        burst_d = '0;
                        if (req[!sel]) begin
                            state_d = other_st;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    burst_d = '0;
                    state_d = req[!sel] ? other_st : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                burst_d = '0;
            end
        endcase
    end

    assign rvalid_d = gnt_int & {2{in_range & !sel_we}};
    assign err_d    = gnt_int & {2{!in_range}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            burst_q  <= '0;
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Every output is squashed while reset is held, including responses in flight.
    assign gnt       = rst ? 2'b00 : gnt_int;
    assign owner     = rst ? 2'b00 : state_q;
    assign rvalid    = rst ? 2'b00 : rvalid_q;
    assign err       = rst ? 2'b00 : err_q;
    assign rdata     = (|rvalid) ? mem_rdata : '0;
    assign mem_en    = (|gnt) & in_range;
    assign mem_we    = mem_en & sel_we;
    assign mem_addr  = mem_en ? sel_addr : '0;
    assign mem_wdata = mem_we ? sel_wdata : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter: a round-robin and a fixed-priority instance,
// each with its own memory, compared every cycle against a behavioural model.
module tb_mem_access_arbiter;

    localparam int MAXB  = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_v       [2];
    logic [1:0]  we_v        [2];
    logic [15:0] addr_v      [2];
    logic [15:0] wdata_v     [2];
    logic [1:0]  gnt_w       [2];
    logic [1:0]  rvalid_w    [2];
    logic [1:0]  err_w       [2];
    logic [1:0]  owner_w     [2];
    logic [7:0]  rdata_w     [2];
    logic        mem_en_w    [2];
    logic        mem_we_w    [2];
    logic [7:0]  mem_addr_w  [2];
    logic [7:0]  mem_wdata_w [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem_dev [DEPTH];
        logic [7:0] mem_rd;

        initial begin
            mem_rd = 8'h00;
            for (int i = 0; i < DEPTH; i++) mem_dev[i] = 8'(i * 37 + 5);
        end

        always @(posedge clk) begin
            if (mem_en_w[g] && mem_addr_w[g] < 8'(DEPTH)) begin
                if (mem_we_w[g]) mem_dev[mem_addr_w[g][5:0]] <= mem_wdata_w[g];
                else             mem_rd <= mem_dev[mem_addr_w[g][5:0]];
            end
        end

        mem_access_arbiter #(
            .ADDR_W   (8),
            .DATA_W   (8),
            .DEPTH    (DEPTH),
            .MAX_BURST(MAXB),
            .PRIO_MODE(g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req      (req_v[g]),
            .we       (we_v[g]),
            .addr     (addr_v[g]),
            .wdata    (wdata_v[g]),
            .gnt      (gnt_w[g]),
            .rvalid   (rvalid_w[g]),
            .err      (err_w[g]),
            .rdata    (rdata_w[g]),
            .mem_en   (mem_en_w[g]),
            .mem_we   (mem_we_w[g]),
            .mem_addr (mem_addr_w[g]),
            .mem_wdata(mem_wdata_w[g]),
            .mem_rdata(mem_rd),
            .owner    (owner_w[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = nobody), grants in current tenure, last winner.
    int         own      [2];
    int         burst    [2];
    int         last     [2];
    logic [1:0] pend_rv  [2];
    logic [1:0] pend_err [2];
    logic [7:0] pend_dat [2];
    logic [7:0] shadow   [2][DEPTH];
    logic [1:0] exp_gnt  [2];
    logic [1:0] pending  [2];

    initial begin
        int density;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_v[k] = '0; we_v[k] = '0; addr_v[k] = '0; wdata_v[k] = '0;
            own[k] = -1; burst[k] = 0; last[k] = 1;
            pend_rv[k] = '0; pend_err[k] = '0; pend_dat[k] = '0;
            exp_gnt[k] = '0; pending[k] = '0;
            for (int i = 0; i < DEPTH; i++) shadow[k][i] = 8'(i * 37 + 5);
        end
        density = 90;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            case ((cyc / 250) % 3)
                0:       density = 90;
                1:       density = 55;
                default: density = 20;
            endcase

            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [1:0] rq;
                logic [7:0] a, wd;
                logic       w, g, inr;
                logic [1:0] eo;
                int         o;
                string      pfx;
                o   = own[k];
                rq  = req_v[k];
                a   = '0; wd = '0; w = 1'b0;
                if (o >= 0) begin
                    a  = addr_v[k][o*8 +: 8];
                    wd = wdata_v[k][o*8 +: 8];
                    w  = we_v[k][o];
                end
                g   = !rst && (o >= 0) && rq[o];
                inr = a < 8'(DEPTH);
                eo  = (rst || o < 0) ? 2'b00 : 2'(1 << o);
                exp_gnt[k] = g ? 2'(1 << o) : 2'b00;
                pfx = (k == 0) ? "rr" : "prio";

                check({pfx, " gnt"},    32'(gnt_w[k]),    32'(exp_gnt[k]));
                check({pfx, " owner"},  32'(owner_w[k]),  32'(eo));
                check({pfx, " mem_en"}, 32'(mem_en_w[k]), 32'(g && inr));
                if (g && inr) begin
                    check({pfx, " mem_addr"}, 32'(mem_addr_w[k]), 32'(a));
                    check({pfx, " mem_we"},   32'(mem_we_w[k]),   32'(w));
                    if (w) check({pfx, " mem_wdata"}, 32'(mem_wdata_w[k]), 32'(wd));
                end
                check({pfx, " rvalid"}, 32'(rvalid_w[k]), rst ? 32'd0 : 32'(pend_rv[k]));
                check({pfx, " err"},    32'(err_w[k]),    rst ? 32'd0 : 32'(pend_err[k]));
                check({pfx, " rdata"},  32'(rdata_w[k]),
                      (rst || pend_rv[k] == 2'b00) ? 32'd0 : 32'(pend_dat[k]));

                if (rst) begin
                    own[k] = -1; burst[k] = 0; last[k] = 1;
                    pend_rv[k] = '0; pend_err[k] = '0; pend_dat[k] = '0;
                end else begin
                    pend_rv[k]  = (g && inr && !w) ? 2'(1 << o) : 2'b00;
                    pend_err[k] = (g && !inr) ? 2'(1 << o) : 2'b00;
                    if (g && inr && !w) pend_dat[k] = shadow[k][a[5:0]];
                    if (g && inr && w)  shadow[k][a[5:0]] = wd;
                    if (o < 0) begin
                        if (rq == 2'b11)      own[k] = (k == 1) ? 0 : 1 - last[k];
                        else if (rq == 2'b01) own[k] = 0;
                        else if (rq == 2'b10) own[k] = 1;
                        burst[k] = 0;
                    end else if (g) begin
                        last[k]  = o;
                        burst[k] = burst[k] + 1;
                        if (burst[k] == MAXB) begin
                            burst[k] = 0;
                            if (rq[1-o]) own[k] = 1 - o;
                        end
                    end else begin
                        burst[k] = 0;
                        own[k]   = rq[1-o] ? 1 - o : -1;
                    end
                end
            end

            @(posedge clk);
            #1;
            rst = (cyc < 2) || ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (exp_gnt[k][p]) pending[k][p] = 1'b0;
                    if (!pending[k][p] && $urandom_range(0, 99) < density) begin
                        pending[k][p]        = 1'b1;
                        we_v[k][p]           = 1'($urandom_range(0, 1));
                        addr_v[k][p*8 +: 8]  = ($urandom_range(0, 7) == 0) ?
                                               8'($urandom_range(64, 255)) :
                                               8'($urandom_range(0, 63));
                        wdata_v[k][p*8 +: 8] = 8'($urandom_range(0, 255));
                    end
                    req_v[k][p] = pending[k][p];
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
